// File: rtl/exunit_custom_sched_if.sv
// Issue / writeback handshake bundle between the custom RS, the sequencer and the result-bus arbiter.
// Signal prefixes are from the sequencer's point of view (i_ = into sequencer, o_ = out of it).
interface exunit_custom_sched_if #(
    parameter int unsigned SPECTAG_LEN = 5,
    parameter int unsigned RRF_SEL     = 6
);
    logic                   i_issue;
    logic                   o_ready;
    logic [2:0]             i_funct3;
    logic                   i_dstval;
    logic [RRF_SEL-1:0]     i_rrftag;
    logic [SPECTAG_LEN-1:0] i_spectag;
    logic                   i_specbit;
    logic                   i_prmiss;
    logic                   i_prsuccess;
    logic [SPECTAG_LEN-1:0] i_spectagfix;
    logic                   o_dp_start;
    logic                   o_wb_req;
    logic                   i_wb_gnt;
    logic                   o_rob_we;
    logic                   o_rrf_we;
    logic [RRF_SEL-1:0]     o_wb_rrftag;
    logic                   o_kill_speculative;

    modport master (
        output i_issue, i_funct3, i_dstval, i_rrftag, i_spectag, i_specbit,
               i_prmiss, i_prsuccess, i_spectagfix, i_wb_gnt,
        input  o_ready, o_dp_start, o_wb_req, o_rob_we, o_rrf_we, o_wb_rrftag,
               o_kill_speculative
    );

    modport slave (
        input  i_issue, i_funct3, i_dstval, i_rrftag, i_spectag, i_specbit,
               i_prmiss, i_prsuccess, i_spectagfix, i_wb_gnt,
        output o_ready, o_dp_start, o_wb_req, o_rob_we, o_rrf_we, o_wb_rrftag,
               o_kill_speculative
    );
endinterface

// File: rtl/exunit_custom_sched.sv
// Issue/writeback sequencer for the custom execution unit: latency count, result-bus request, mispredict squash.
// Define CUSTOM_SCHED_PERF_EN to add the o_perf_issued / o_perf_killed event counters.
module exunit_custom_sched #(
    parameter int unsigned SPECTAG_LEN = 5,
    parameter int unsigned RRF_SEL     = 6,
    parameter int unsigned BASE_LAT    = 1,
    parameter int unsigned CNT_W       = 4
) (
    input  logic                clk,
    input  logic                reset,
    exunit_custom_sched_if.slave bus
`ifdef CUSTOM_SCHED_PERF_EN
    ,
    output logic [31:0]         o_perf_issued,
    output logic [31:0]         o_perf_killed
`endif
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_WB   = 2'd2;

    logic [1:0]             r_state;
    logic [1:0]             w_state_nxt;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic [CNT_W-1:0]       w_load;
    logic                   r_dstval;
    logic                   r_specbit;
    logic                   r_dp_start;
    logic [RRF_SEL-1:0]     r_rrftag;
    logic [SPECTAG_LEN-1:0] r_spectag;

    logic w_kill;
    logic w_drop;
    logic w_grant;
    logic w_ready;
    logic w_accept;
    logic w_clr_spec;
    logic w_new_spec;

    // Squash/drop/confirm decisions for the held op and for the op being presented
    assign w_kill     = (r_state != S_IDLE) & r_specbit & (|(r_spectag & bus.i_spectagfix)) & bus.i_prmiss;
    assign w_drop     = bus.i_specbit & (|(bus.i_spectag & bus.i_spectagfix)) & bus.i_prmiss;
    assign w_clr_spec = bus.i_prsuccess & ~bus.i_prmiss & (|(r_spectag & bus.i_spectagfix));
    assign w_new_spec = bus.i_specbit &
                        ~(bus.i_prsuccess & ~bus.i_prmiss & (|(bus.i_spectag & bus.i_spectagfix)));

    assign w_grant  = (r_state == S_WB) & bus.i_wb_gnt & ~w_kill;
    assign w_ready  = (r_state == S_IDLE) | w_grant;
    assign w_accept = bus.i_issue & w_ready & ~w_drop;
    assign w_load   = CNT_W'(BASE_LAT) + CNT_W'(bus.i_funct3) - CNT_W'(1);

    // Next-state: a same-cycle accept overrides whatever the current state decided
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: ;
            S_BUSY: begin
                if (w_kill) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) w_state_nxt = S_WB;
                end
            end
            S_WB: begin
                if (w_kill || bus.i_wb_gnt) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_accept) begin
            w_cnt_nxt   = w_load;
            w_state_nxt = (w_load != '0) ? S_BUSY : S_WB;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_dstval   <= 1'b0;
            r_specbit  <= 1'b0;
            r_dp_start <= 1'b0;
            r_rrftag   <= '0;
            r_spectag  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_dp_start <= w_accept;
            if (w_accept) begin
                r_dstval  <= bus.i_dstval;
                r_rrftag  <= bus.i_rrftag;
                r_spectag <= bus.i_spectag;
                r_specbit <= w_new_spec;
            end else if (w_clr_spec) begin
                r_specbit <= 1'b0;
            end
        end
    end

    // ready/rob_we/rrf_we/kill follow the same-cycle grant and mispredict inputs
    assign bus.o_ready            = w_ready;
    assign bus.o_dp_start         = r_dp_start;
    assign bus.o_wb_req           = (r_state == S_WB);
    assign bus.o_rob_we           = w_grant;
    assign bus.o_rrf_we           = w_grant & r_dstval;
    assign bus.o_wb_rrftag        = r_rrftag;
    assign bus.o_kill_speculative = w_kill;

`ifdef CUSTOM_SCHED_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_perf_issued <= '0;
            o_perf_killed <= '0;
        end else begin
            if (w_accept) o_perf_issued <= o_perf_issued + 32'd1;
            if (w_kill)   o_perf_killed <= o_perf_killed + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_exunit_custom_sched.sv
// Randomized + directed bench for exunit_custom_sched against a cycle-timeline reference model.
// Honours CUSTOM_SCHED_PERF_EN when the design is built with it.
module tb_exunit_custom_sched;
    localparam int unsigned SL       = 5;
    localparam int unsigned RS       = 6;
    localparam int unsigned BASE_LAT = 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    exunit_custom_sched_if #(.SPECTAG_LEN(SL), .RRF_SEL(RS)) bus ();

`ifdef CUSTOM_SCHED_PERF_EN
    logic [31:0] perf_issued;
    logic [31:0] perf_killed;
`endif

    exunit_custom_sched #(
        .SPECTAG_LEN(SL), .RRF_SEL(RS), .BASE_LAT(BASE_LAT), .CNT_W(4)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef CUSTOM_SCHED_PERF_EN
        ,
        .o_perf_issued (perf_issued),
        .o_perf_killed (perf_killed)
`endif
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Model: an in-flight op finishes its latency at an absolute cycle number
    bit          m_busy     = 1'b0;
    int          m_wb_cyc   = 0;
    int          m_last_acc = -100;
    bit          m_dst      = 1'b0;
    bit          m_spec     = 1'b0;
    logic [SL-1:0] m_tag    = '0;
    logic [RS-1:0] m_rrf    = '0;
    int unsigned m_issued   = 0;
    int unsigned m_killed   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic step(input bit iss, input logic [2:0] f3, input bit dv, input logic [RS-1:0] tag,
                        input logic [SL-1:0] st, input bit sb, input bit pm, input bit ps,
                        input logic [SL-1:0] fix, input bit gnt);
        bit e_kill, e_wbreq, e_rob, e_ready, e_dp, drop, acc;
        @(negedge clk);
        bus.i_issue = iss;   bus.i_funct3 = f3;    bus.i_dstval = dv;       bus.i_rrftag = tag;
        bus.i_spectag = st;  bus.i_specbit = sb;   bus.i_prmiss = pm;       bus.i_prsuccess = ps;
        bus.i_spectagfix = fix;                    bus.i_wb_gnt = gnt;
        #1;
        e_kill  = m_busy && m_spec && ((m_tag & fix) != '0) && pm;
        e_wbreq = m_busy && (cyc >= m_wb_cyc);
        e_rob   = e_wbreq && gnt && !e_kill;
        e_ready = !m_busy || e_rob;
        e_dp    = (cyc == m_last_acc + 1);
        drop    = sb && ((st & fix) != '0) && pm;
        acc     = iss && e_ready && !drop;
        chk("ready",    32'(bus.o_ready),            32'(e_ready));
        chk("dp_start", 32'(bus.o_dp_start),         32'(e_dp));
        chk("wb_req",   32'(bus.o_wb_req),           32'(e_wbreq));
        chk("rob_we",   32'(bus.o_rob_we),           32'(e_rob));
        chk("rrf_we",   32'(bus.o_rrf_we),           32'(e_rob && m_dst));
        chk("kill",     32'(bus.o_kill_speculative), 32'(e_kill));
        if (e_rob) chk("wb_rrftag", 32'(bus.o_wb_rrftag), 32'(m_rrf));
`ifdef CUSTOM_SCHED_PERF_EN
        chk("perf_issued", perf_issued, m_issued);
        chk("perf_killed", perf_killed, m_killed);
`endif
        if (e_kill) begin
            m_busy = 1'b0;
            m_killed++;
        end
        if (e_rob) m_busy = 1'b0;
        if (!pm && ps && ((m_tag & fix) != '0)) m_spec = 1'b0;
        if (acc) begin
            m_busy     = 1'b1;
            m_wb_cyc   = cyc + int'(BASE_LAT) + int'(f3);
            m_last_acc = cyc;
            m_dst      = dv;
            m_rrf      = tag;
            m_tag      = st;
            m_spec     = sb && !(ps && !pm && ((st & fix) != '0));
            m_issued++;
        end
        cyc++;
    endtask

    task automatic idle(input bit gnt);
        step(1'b0, 3'd0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, gnt);
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_ready"}, 32'(bus.o_ready),            32'd1);
        chk({name, "_dp"},    32'(bus.o_dp_start),         32'd0);
        chk({name, "_wbreq"}, 32'(bus.o_wb_req),           32'd0);
        chk({name, "_rob"},   32'(bus.o_rob_we),           32'd0);
        chk({name, "_rrf"},   32'(bus.o_rrf_we),           32'd0);
        chk({name, "_kill"},  32'(bus.o_kill_speculative), 32'd0);
        chk({name, "_tag"},   32'(bus.o_wb_rrftag),        32'd0);
`ifdef CUSTOM_SCHED_PERF_EN
        chk({name, "_pi"}, perf_issued, 32'd0);
        chk({name, "_pk"}, perf_killed, 32'd0);
`endif
    endtask

    initial begin
        reset = 1'b0;
        bus.i_issue = 1'b0;   bus.i_funct3 = '0;    bus.i_dstval = 1'b0;     bus.i_rrftag = '0;
        bus.i_spectag = '0;   bus.i_specbit = 1'b0; bus.i_prmiss = 1'b0;     bus.i_prsuccess = 1'b0;
        bus.i_spectagfix = '0;                      bus.i_wb_gnt = 1'b1;
        #3;
        chk_reset_outputs("rst");
        @(negedge clk);
        reset = 1'b1;

        // 1: funct3=2 -> L=3, grant always available
        step(1'b1, 3'd2, 1'b1, 6'd5, '0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
        chk("t1_ready", 32'(bus.o_ready), 32'd1);
        idle(1'b1);
        chk("t1_dp", 32'(bus.o_dp_start), 32'd1);
        idle(1'b1);
        chk("t1_wbreq", 32'(bus.o_wb_req), 32'd0);
        idle(1'b1);
        chk("t1_rob", 32'(bus.o_rob_we), 32'd1);
        chk("t1_rrf", 32'(bus.o_rrf_we), 32'd1);
        chk("t1_tag", 32'(bus.o_wb_rrftag), 32'd5);

        // 2: funct3=0 straight to WB, grant withheld for 4 cycles
        step(1'b1, 3'd0, 1'b0, 6'd7, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            idle(1'b0);
            chk("t2_wbreq", 32'(bus.o_wb_req), 32'd1);
            chk("t2_ready", 32'(bus.o_ready), 32'd0);
        end
        idle(1'b1);
        chk("t2_rob", 32'(bus.o_rob_we), 32'd1);
        chk("t2_rrf", 32'(bus.o_rrf_we), 32'd0);

        // 3: speculative op squashed while counting
        step(1'b1, 3'd3, 1'b1, 6'd11, 5'b00100, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        idle(1'b0);
        step(1'b0, 3'd0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 5'b00100, 1'b1);
        chk("t3_kill", 32'(bus.o_kill_speculative), 32'd1);
        chk("t3_ready", 32'(bus.o_ready), 32'd0);
        chk("t3_rob", 32'(bus.o_rob_we), 32'd0);
        for (int i = 0; i < 6; i++) begin
            idle(1'b1);
            chk("t3_norob", 32'(bus.o_rob_we), 32'd0);
            chk("t3_nokill", 32'(bus.o_kill_speculative), 32'd0);
        end

        // 4a: kill in WB with grant the same cycle
        step(1'b1, 3'd0, 1'b1, 6'd12, 5'b01000, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        step(1'b0, 3'd0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 5'b01000, 1'b1);
        chk("t4_rob", 32'(bus.o_rob_we), 32'd0);
        chk("t4_kill", 32'(bus.o_kill_speculative), 32'd1);
        chk("t4_wbreq", 32'(bus.o_wb_req), 32'd1);
        // 4b: prsuccess confirms the op, later prmiss on same tag is ignored
        step(1'b1, 3'd2, 1'b1, 6'd13, 5'b00010, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        step(1'b0, 3'd0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 5'b00010, 1'b0);
        idle(1'b0);
        step(1'b0, 3'd0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 5'b00010, 1'b1);
        chk("t4_nokill", 32'(bus.o_kill_speculative), 32'd0);
        chk("t4_rob2", 32'(bus.o_rob_we), 32'd1);
        chk("t4_tag", 32'(bus.o_wb_rrftag), 32'd13);

        // 5: back-to-back issue during the grant cycle
        step(1'b1, 3'd0, 1'b1, 6'd3, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        step(1'b1, 3'd1, 1'b1, 6'd9, '0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
        chk("t5_rob", 32'(bus.o_rob_we), 32'd1);
        chk("t5_tag", 32'(bus.o_wb_rrftag), 32'd3);
        chk("t5_ready", 32'(bus.o_ready), 32'd1);
        idle(1'b1);
        chk("t5_dp", 32'(bus.o_dp_start), 32'd1);
        chk("t5_busy", 32'(bus.o_rob_we), 32'd0);
        idle(1'b1);
        chk("t5_rob2", 32'(bus.o_rob_we), 32'd1);
        chk("t5_tag2", 32'(bus.o_wb_rrftag), 32'd9);

        // 6: asynchronous reset in the middle of a long op
        step(1'b1, 3'd5, 1'b1, 6'd20, '0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
        idle(1'b1);
        idle(1'b1);
        #1 reset = 1'b0;
        #1;
        chk_reset_outputs("t6");
        m_busy = 1'b0; m_last_acc = -100; m_issued = 0; m_killed = 0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            idle(1'b1);
            chk("t6_norob", 32'(bus.o_rob_we), 32'd0);
        end

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            logic [SL-1:0] st, fix;
            st  = SL'(1) << ($urandom % SL);
            fix = ($urandom % 2 == 0) ? m_tag : (SL'(1) << ($urandom % SL));
            step(($urandom % 3) != 0, 3'($urandom), 1'($urandom), RS'($urandom), st,
                 1'($urandom), ($urandom % 6) == 0, ($urandom % 5) == 0, fix, ($urandom % 3) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
